cpu_run_ctrl: RTL

- Sequences the single-cycle core (xgriscv_sc) for bring-up and regression runs.
- Loads a program into instruction memory through a valid/ready stream while holding the core in reset, then releases the core and counts run cycles.
- Stops the core when its writeback PC (pcW) matches a programmable halt address.
- Sits between the host/loader logic, the instruction-memory write port and the core's reset input.

---
 rtl/cpu_run_ctrl_if.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Loader word stream into the run controller (valid/ready handshake).
//   ld_valid  loader word valid              (master -> slave)
//   ld_ready  controller accepts a word      (slave  -> master)
//   ld_addr   instruction word address       (master -> slave)
//   ld_data   32-bit instruction word        (master -> slave)
//   ld_last   final word of the program      (master -> slave)
// master = host/loader side, slave = cpu_run_ctrl.
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_last;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Bring-up sequencer for the single-cycle core xgriscv_sc. Holds the core in
// reset while a program is streamed into instruction memory, releases it,
// counts run cycles and stops it when the writeback PC hits halt_pc.
//
// Optional feature macro: RUN_WATCHDOG_EN
//   defined   : RUN stops after WDOG_LIMIT cycles without a halt match and
//               raises timeout
//   undefined : no cycle limit, timeout is constant 0
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   start             pulse: begin a load/run sequence (IDLE or HALT only)
//   skip_load         sampled with start; 1 = go straight to RUN
//   abort             return to IDLE from any state (highest priority)
//   ld                loader stream (cpu_run_ctrl_if.slave)
//   imem_we/waddr/wdata  instruction-memory write port, 1 cycle after accept
//   cpu_rstn          core reset, active-low, high only in RUN
//   pcW, halt_pc      core writeback PC and the address that stops it
//   busy, done        state is LOAD/RUN, state is HALT
//   load_err          sticky: a word arrived with ld_addr >= IMEM_DEPTH
//   timeout           watchdog stop flag
//   cycle_cnt         RUN cycle count, saturating
//   state             IDLE=00, LOAD=01, RUN=10, HALT=11
// All outputs are registered.
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              skip_load,
  input  logic              abort,
  cpu_run_ctrl_if.slave     ld,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  input  logic [31:0]       pcW,
  input  logic [31:0]       halt_pc,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

`ifdef RUN_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
  localparam logic [31:0]      DEPTH_U   = 32'(IMEM_DEPTH);

  state_t st;
  logic   ld_ready_r;
  logic   timeout_r;
  // High during the first RUN cycle, while the core is still leaving reset
  // and pcW is not yet meaningful.
  logic   run_first;
  logic   xfer;
  logic   in_range;
  logic   halt_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign xfer     = ld.ld_valid & ld_ready_r;
  assign in_range = (32'(ld.ld_addr) < DEPTH_U);
  assign halt_hit = !run_first && (pcW == halt_pc);

  assign ld.ld_ready = ld_ready_r;
  assign state       = st;
  assign timeout     = WDOG_ON ? timeout_r : 1'b0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st         <= IDLE;
      cpu_rstn   <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      ld_ready_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
      timeout_r  <= 1'b0;
      cycle_cnt  <= '0;
      run_first  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (abort) begin
        st         <= IDLE;
        cpu_rstn   <= 1'b0;
        ld_ready_r <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
        run_first  <= 1'b0;
      end else begin
        case (st)
          IDLE, HALT: begin
            if (start) begin
              cycle_cnt <= '0;
              load_err  <= 1'b0;
              timeout_r <= 1'b0;
              busy      <= 1'b1;
              done      <= 1'b0;
              if (skip_load) begin
                st        <= RUN;
                cpu_rstn  <= 1'b1;
                run_first <= 1'b1;
              end else begin
                st         <= LOAD;
                ld_ready_r <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (xfer) begin
              // Out-of-range words are consumed so the stream never stalls.
              if (in_range) begin
                imem_we    <= 1'b1;
                imem_waddr <= ld.ld_addr;
                imem_wdata <= ld.ld_data;
              end else begin
                load_err <= 1'b1;
              end
              if (ld.ld_last) begin
                st         <= RUN;
                ld_ready_r <= 1'b0;
                cpu_rstn   <= 1'b1;
                run_first  <= 1'b1;
              end
            end
          end
          RUN: begin
            cycle_cnt <= sat_inc(cycle_cnt);
            run_first <= 1'b0;
            // A halt match outranks the watchdog, leaving timeout clear.
            if (halt_hit || (WDOG_ON && (cycle_cnt == WDOG_LAST))) begin
              st       <= HALT;
              cpu_rstn <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              if (!halt_hit) timeout_r <= 1'b1;
            end
          end
          default: begin
            st <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
